uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Packet-level round-robin arbiter that shares one UART transmit FIFO between up to 16 requesters. It sits directly in front of the FIFO write port of `uart_tx_fifo` and drives its `wr_en`/`wr_data` while honouring its `ready`. A grant is held until the requester's last byte, so bytes from different sources never interleave on the line. An optional channel-ID header byte precedes each packet, and a length watchdog stops any single requester from holding the link indefinitely.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `MAX_PKT_LEN`, default 16: maximum data bytes per grant; legal range 1..255.
- `HDR_EN`, default 1: 1 inserts a header byte `{4'hA, id[3:0]}` before each packet's data.
- `clk` input 1: system clock; the only clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input NUM_REQ: per-requester byte valid.
- `req_data` input 8*NUM_REQ: per-requester byte; requester i uses bits [8i+7:8i].
- `req_last` input NUM_REQ: marks the final byte of a packet; qualified by `req_valid`.
- `req_ready` output NUM_REQ: per-requester byte accepted when `req_valid` is also high.
- `o_wr_en` output 1: FIFO write strobe.
- `o_wr_data` output 8: FIFO write data.
- `i_ready` input 1: FIFO not full; connect to `uart_tx_fifo.ready`.
- `o_grant` output NUM_REQ: registered, one-hot or zero; the current owner.
- `o_busy` output 1: high when state is not IDLE.
- `o_trunc` output 1: one-cycle pulse when the watchdog ends a grant.

## Operation
- State machine is registered with three states: IDLE, HDR, DATA.
- IDLE:
  - If any `req_valid` bit is high, select the first requester with valid high, searching circularly from `rr_ptr+1`.
  - Register it into `o_grant` and `rr_ptr`, clear `byte_cnt`.
  - Go to HDR if `HDR_EN`=1, else go to DATA.
- HDR:
  - `o_wr_en` = `i_ready`; `o_wr_data` = `{4'hA, grant_id}`.
  - When `o_wr_en` is high, go to DATA.
- DATA:
  - `req_ready[g]` = `i_ready`; `o_wr_en` = `req_valid[g]` & `i_ready`; `o_wr_data` = `req_data[g]`.
  - A beat is `o_wr_en` high. On each beat, `byte_cnt` increments.
  - On a beat with `req_last[g]` high, go to IDLE and clear `o_grant`.
  - On a beat where `byte_cnt`==`MAX_PKT_LEN`-1 and `req_last` is low, go to IDLE, clear `o_grant`, and pulse `o_trunc` on the next cycle. The requester's remaining bytes compete as a new packet.
- `req_ready` is 0 for all non-granted requesters and in IDLE/HDR. `o_wr_data` is 0 whenever `o_wr_en` is 0.
- A requester dropping `req_valid` mid-packet only stalls; the grant is held.
- `byte_cnt` is 8 bits wide and never wraps, because of the watchdog.
- Reset values: state IDLE, `o_grant`=0, `rr_ptr`=NUM_REQ-1 (requester 0 wins first), `byte_cnt`=0, `o_trunc`=0. Combinational outputs are therefore `o_wr_en`=0, `req_ready`=0, `o_busy`=0, `o_wr_data`=0.
- Reset asserted mid-packet: everything returns to reset values immediately. The partial packet stays in the FIFO; recovery is the requester's responsibility.

## Timing
- `req_valid` rises in cycle 0 with IDLE:
  - `o_grant` is valid in cycle 1.
  - Header beat in cycle 1 if `i_ready`.
  - First data beat in cycle 2; it is cycle 1 when `HDR_EN`=0.
- Data throughput is one byte per cycle while `req_valid` and `i_ready` are both high.
- Exactly one IDLE cycle separates consecutive grants.
- `req_ready`, `o_wr_en` and `o_wr_data` are combinational from state, `o_grant`, `req_*` and `i_ready`. There is no combinational path from `req_valid` to `req_ready`.
- `i_ready` low: no beat occurs, and data/header are held until accepted.

## Test plan
- Single requester: requester 1 sends 0x11,0x22,0x33 (last on 0x33), HDR_EN=1, i_ready=1 -> FIFO receives 0xA1,0x11,0x22,0x33 on consecutive cycles; `o_grant`=4'b0010 throughout; IDLE one cycle later.
- Round-robin: all four requesters hold 2-byte packets from reset -> grant order 0,1,2,3,0; one IDLE cycle between packets; no interleaving.
- Backpressure: `i_ready` low for 5 cycles mid-packet -> no `o_wr_en` and no `req_ready` during the stall; the stalled byte is written once on resume; no loss or duplication.
- Watchdog: MAX_PKT_LEN=4, requester 2 streams 6 bytes with last on the 6th, sole requester -> bytes 1-4 under the first header; `o_trunc` pulses once; second header 0xA2 then bytes 5-6.
- Reset mid-packet: `rst_n` low asynchronously during DATA -> `o_grant`=0, `o_wr_en`=0, `req_ready`=0 immediately without waiting for a clock edge; after release, requester 0 wins first.
- HDR_EN=0 with NUM_REQ=2: alternating 1-byte packets from both requesters -> no header bytes; first data beat one cycle after valid; a beat every second cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the write port of uart_tx_fifo.
// A grant is held until the owner's last byte or until the length watchdog expires.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned MAX_PKT_LEN = 16,
   parameter bit          HDR_EN      = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   o_wr_en,
   output logic [7:0]             o_wr_data,
   input  logic                   i_ready,
   output logic [NUM_REQ-1:0]     o_grant,
   output logic                   o_busy,
   output logic                   o_trunc
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [3:0]         rr_ptr, rr_ptr_nxt;
   logic [7:0]         byte_cnt, byte_cnt_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   logic               trunc_nxt;

   logic               pick_any;
   logic [3:0]         pick_id;
   logic               sel_valid;
   logic               sel_last;
   logic [7:0]         sel_data;

   // Circular search from rr_ptr+1: indices above rr_ptr first, then wrap to 0..rr_ptr.
   always_comb begin
      pick_any = 1'b0;
      pick_id  = rr_ptr;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!pick_any && req_valid[i] && (4'(i) > rr_ptr)) begin
            pick_any = 1'b1;
            pick_id  = 4'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!pick_any && req_valid[i] && (4'(i) <= rr_ptr)) begin
            pick_any = 1'b1;
            pick_id  = 4'(i);
         end
      end
   end

   // rr_ptr doubles as the id of the current owner while a grant is held.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (4'(i) == rr_ptr) begin
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
            sel_data  = req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      byte_cnt_nxt = byte_cnt;
      grant_nxt    = o_grant;
      trunc_nxt    = 1'b0;
      o_wr_en      = 1'b0;
      o_wr_data    = '0;
      req_ready    = '0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_nxt    = HDR_EN ? HDR : DATA;
               rr_ptr_nxt   = pick_id;
               byte_cnt_nxt = '0;
               for (int unsigned i = 0; i < NUM_REQ; i++) begin
                  grant_nxt[i] = (4'(i) == pick_id);
               end
            end
         end
         HDR: begin
            o_wr_en = i_ready;
            if (i_ready) begin
               o_wr_data = {4'hA, rr_ptr};
               state_nxt = DATA;
            end
         end
         DATA: begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               req_ready[i] = o_grant[i] & i_ready;
            end
            o_wr_en = sel_valid & i_ready;
            if (o_wr_en) begin
               o_wr_data    = sel_data;
               byte_cnt_nxt = byte_cnt + 8'd1;
               if (sel_last) begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
               end else if (byte_cnt == 8'(MAX_PKT_LEN - 1)) begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
                  trunc_nxt = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   assign o_busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= 4'(NUM_REQ - 1);
         byte_cnt <= '0;
         o_grant  <= '0;
         o_trunc  <= 1'b0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         byte_cnt <= byte_cnt_nxt;
         o_grant  <= grant_nxt;
         o_trunc  <= trunc_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: three instances (default, short watchdog,
// two requesters without header) share one set of requester inputs.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic        i_ready;

   logic [3:0]  a_ready, a_grant;
   logic        a_wr_en, a_busy, a_trunc;
   logic [7:0]  a_wr_data;
   logic [3:0]  b_ready, b_grant;
   logic        b_wr_en, b_busy, b_trunc;
   logic [7:0]  b_wr_data;
   logic [1:0]  c_ready, c_grant;
   logic        c_wr_en, c_busy, c_trunc;
   logic [7:0]  c_wr_data;

   typedef struct packed {
      logic       wr_en;
      logic [7:0] wr_data;
      logic [3:0] ready;
      logic [3:0] grant;
      logic       busy;
      logic       trunc;
   } rec_t;

   rec_t       tr[$];
   logic [8:0] q[4][$];
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(4), .MAX_PKT_LEN(16), .HDR_EN(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(a_ready), .o_wr_en(a_wr_en),
      .o_wr_data(a_wr_data), .i_ready(i_ready), .o_grant(a_grant),
      .o_busy(a_busy), .o_trunc(a_trunc));

   uart_tx_arbiter #(.NUM_REQ(4), .MAX_PKT_LEN(4), .HDR_EN(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(b_ready), .o_wr_en(b_wr_en),
      .o_wr_data(b_wr_data), .i_ready(i_ready), .o_grant(b_grant),
      .o_busy(b_busy), .o_trunc(b_trunc));

   uart_tx_arbiter #(.NUM_REQ(2), .MAX_PKT_LEN(16), .HDR_EN(1'b0)) u_c (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1:0]), .req_data(req_data[15:0]),
      .req_last(req_last[1:0]), .req_ready(c_ready), .o_wr_en(c_wr_en),
      .o_wr_data(c_wr_data), .i_ready(i_ready), .o_grant(c_grant),
      .o_busy(c_busy), .o_trunc(c_trunc));

   // One cycle: present queue heads at negedge, record the chosen instance, pop on handshake.
   task automatic step(input int sel, input logic rdy);
      rec_t r;
      @(negedge clk);
      i_ready = rdy;
      for (int i = 0; i < 4; i++) begin
         req_valid[i]       = (q[i].size() != 0);
         req_data[8*i +: 8] = req_valid[i] ? q[i][0][7:0] : 8'h00;
         req_last[i]        = req_valid[i] ? q[i][0][8] : 1'b0;
      end
      #1;
      case (sel)
         0:       r = {a_wr_en, a_wr_data, a_ready, a_grant, a_busy, a_trunc};
         1:       r = {b_wr_en, b_wr_data, b_ready, b_grant, b_busy, b_trunc};
         default: r = {c_wr_en, c_wr_data, 2'b00, c_ready, 2'b00, c_grant, c_busy, c_trunc};
      endcase
      tr.push_back(r);
      for (int i = 0; i < 4; i++) begin
         if (r.ready[i] && req_valid[i]) void'(q[i].pop_front());
      end
      @(posedge clk);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 4; i++) q[i].delete();
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      i_ready   = 1'b1;
      rst_n     = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tr.delete();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      i_ready   = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (a_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", a_grant); end
      checks++; if (a_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", a_wr_en); end
      checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", a_ready); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
      checks++; if (a_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", a_wr_data); end
      checks++; if (a_trunc !== 1'b0) begin errors++; $display("FAIL reset_trunc: got %b want 0", a_trunc); end
      @(negedge clk);
      rst_n = 1'b1;
      tr.delete();
      step(0, 1'b1);
      step(0, 1'b1);
      checks++; if (tr[1].busy !== 1'b0 || tr[1].grant !== 4'b0000) begin
         errors++; $display("FAIL idle_no_req: got busy=%b grant=%b want 0/0000", tr[1].busy, tr[1].grant);
      end
   endtask

   task automatic test_single();
      logic [5:0] en_e = 6'b011110;
      logic [7:0] d_e[6];
      logic [3:0] g_e, rdy_e;
      d_e = '{8'h00, 8'hA1, 8'h11, 8'h22, 8'h33, 8'h00};
      do_reset();
      q[1].push_back(9'h011); q[1].push_back(9'h022); q[1].push_back(9'h133);
      for (int c = 0; c < 6; c++) step(0, 1'b1);
      for (int c = 0; c < 6; c++) begin
         g_e   = en_e[c] ? 4'b0010 : 4'b0000;
         rdy_e = (c >= 2 && c <= 4) ? 4'b0010 : 4'b0000;
         checks++; if (tr[c].wr_en !== en_e[c]) begin errors++; $display("FAIL single_wr_en[%0d]: got %b want %b", c, tr[c].wr_en, en_e[c]); end
         checks++; if (tr[c].wr_data !== d_e[c]) begin errors++; $display("FAIL single_data[%0d]: got %h want %h", c, tr[c].wr_data, d_e[c]); end
         checks++; if (tr[c].grant !== g_e) begin errors++; $display("FAIL single_grant[%0d]: got %b want %b", c, tr[c].grant, g_e); end
         checks++; if (tr[c].busy !== en_e[c]) begin errors++; $display("FAIL single_busy[%0d]: got %b want %b", c, tr[c].busy, en_e[c]); end
         checks++; if (tr[c].ready !== rdy_e) begin errors++; $display("FAIL single_ready[%0d]: got %b want %b", c, tr[c].ready, rdy_e); end
      end
   endtask

   task automatic test_round_robin();
      int         ord[5];
      int         p, ph;
      logic       en_e;
      logic [7:0] d_e;
      logic [3:0] g_e, g4;
      ord = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         q[i].push_back({1'b0, 4'(i), 4'h1});
         q[i].push_back({1'b1, 4'(i), 4'h2});
      end
      q[0].push_back(9'h005); q[0].push_back(9'h106);
      for (int c = 0; c < 21; c++) step(0, 1'b1);
      for (int c = 0; c < 21; c++) begin
         p  = c / 4;
         ph = c % 4;
         g4 = 4'(ord[p % 5]);
         if (c == 20 || ph == 0) begin
            en_e = 1'b0; d_e = 8'h00; g_e = 4'b0000;
         end else begin
            en_e = 1'b1;
            g_e  = 4'b0001 << g4;
            if (ph == 1)      d_e = {4'hA, g4};
            else if (p == 4)  d_e = (ph == 2) ? 8'h05 : 8'h06;
            else              d_e = {g4, (ph == 2) ? 4'h1 : 4'h2};
         end
         checks++; if (tr[c].wr_en !== en_e) begin errors++; $display("FAIL rr_wr_en[%0d]: got %b want %b", c, tr[c].wr_en, en_e); end
         checks++; if (tr[c].wr_data !== d_e) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", c, tr[c].wr_data, d_e); end
         checks++; if (tr[c].grant !== g_e) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", c, tr[c].grant, g_e); end
      end
   endtask

   task automatic test_backpressure();
      logic [10:0] en_e = 11'b01100000110;
      logic [7:0]  d_e[11];
      logic [3:0]  g_e, rdy_e;
      d_e = '{8'h00, 8'hA3, 8'h31, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h32, 8'h33, 8'h00};
      do_reset();
      q[3].push_back(9'h031); q[3].push_back(9'h032); q[3].push_back(9'h133);
      for (int c = 0; c < 11; c++) step(0, (c >= 3 && c <= 7) ? 1'b0 : 1'b1);
      for (int c = 0; c < 11; c++) begin
         g_e   = (c >= 1 && c <= 9) ? 4'b1000 : 4'b0000;
         rdy_e = (c == 2 || c == 8 || c == 9) ? 4'b1000 : 4'b0000;
         checks++; if (tr[c].wr_en !== en_e[c]) begin errors++; $display("FAIL bp_wr_en[%0d]: got %b want %b", c, tr[c].wr_en, en_e[c]); end
         checks++; if (tr[c].wr_data !== d_e[c]) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", c, tr[c].wr_data, d_e[c]); end
         checks++; if (tr[c].ready !== rdy_e) begin errors++; $display("FAIL bp_ready[%0d]: got %b want %b", c, tr[c].ready, rdy_e); end
         checks++; if (tr[c].grant !== g_e) begin errors++; $display("FAIL bp_grant[%0d]: got %b want %b", c, tr[c].grant, g_e); end
      end
   endtask

   task automatic test_watchdog();
      logic [10:0] en_e = 11'b01110111110;
      logic [10:0] tr_e = 11'b00001000000;
      logic [7:0]  d_e[11];
      d_e = '{8'h00, 8'hA2, 8'h51, 8'h52, 8'h53, 8'h54, 8'h00, 8'hA2, 8'h55, 8'h56, 8'h00};
      do_reset();
      for (int i = 1; i <= 6; i++) q[2].push_back({(i == 6), 8'h50 + 8'(i)});
      for (int c = 0; c < 11; c++) step(1, 1'b1);
      for (int c = 0; c < 11; c++) begin
         checks++; if (tr[c].wr_en !== en_e[c]) begin errors++; $display("FAIL wd_wr_en[%0d]: got %b want %b", c, tr[c].wr_en, en_e[c]); end
         checks++; if (tr[c].wr_data !== d_e[c]) begin errors++; $display("FAIL wd_data[%0d]: got %h want %h", c, tr[c].wr_data, d_e[c]); end
         checks++; if (tr[c].trunc !== tr_e[c]) begin errors++; $display("FAIL wd_trunc[%0d]: got %b want %b", c, tr[c].trunc, tr_e[c]); end
      end
      checks++; if (tr[6].grant !== 4'b0000 || tr[7].grant !== 4'b0100) begin
         errors++; $display("FAIL wd_regrant: got %b,%b want 0000,0100", tr[6].grant, tr[7].grant);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 1; i <= 5; i++) q[1].push_back({(i == 5), 8'h40 + 8'(i)});
      for (int c = 0; c < 4; c++) step(0, 1'b1);
      @(negedge clk);
      #1;
      checks++; if (a_wr_en !== 1'b1 || a_grant !== 4'b0010) begin
         errors++; $display("FAIL rstmid_pre: got wr_en=%b grant=%b want 1/0010", a_wr_en, a_grant);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (a_grant !== 4'b0000) begin errors++; $display("FAIL rstmid_grant: got %b want 0000", a_grant); end
      checks++; if (a_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en: got %b want 0", a_wr_en); end
      checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_ready: got %b want 0000", a_ready); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", a_busy); end
      for (int i = 0; i < 4; i++) q[i].delete();
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tr.delete();
      q[0].push_back(9'h101);
      q[1].push_back(9'h111);
      for (int c = 0; c < 3; c++) step(0, 1'b1);
      checks++; if (tr[1].wr_data !== 8'hA0 || tr[1].grant !== 4'b0001) begin
         errors++; $display("FAIL rstmid_first_winner: got data=%h grant=%b want A0/0001", tr[1].wr_data, tr[1].grant);
      end
   endtask

   task automatic test_no_header();
      logic [7:0] d_e[9];
      logic [3:0] g_e[9];
      logic       en_e;
      d_e = '{8'h00, 8'hC0, 8'h00, 8'hC1, 8'h00, 8'hC2, 8'h00, 8'hC3, 8'h00};
      g_e = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0};
      do_reset();
      q[0].push_back(9'h1C0); q[0].push_back(9'h1C2);
      q[1].push_back(9'h1C1); q[1].push_back(9'h1C3);
      for (int c = 0; c < 9; c++) step(2, 1'b1);
      for (int c = 0; c < 9; c++) begin
         en_e = (c % 2 == 1) && (c < 8);
         checks++; if (tr[c].wr_en !== en_e) begin errors++; $display("FAIL nohdr_wr_en[%0d]: got %b want %b", c, tr[c].wr_en, en_e); end
         checks++; if (tr[c].wr_data !== d_e[c]) begin errors++; $display("FAIL nohdr_data[%0d]: got %h want %h", c, tr[c].wr_data, d_e[c]); end
         checks++; if (tr[c].grant !== g_e[c]) begin errors++; $display("FAIL nohdr_grant[%0d]: got %b want %b", c, tr[c].grant, g_e[c]); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_watchdog();
      test_reset_mid();
      test_no_header();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
